// File: rtl/msi_arb_pkg.sv
// Shared types and widths for the MSI interrupt arbiter.
// The HOLD state exists only when MSI_HOLDOFF_EN is defined.
package msi_arb_pkg;

  localparam int MSI_VEC_W = 5;
  localparam int MAX_SRC   = 32;

`ifdef MSI_HOLDOFF_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } arb_state_e;
`endif

endpackage

// File: rtl/msi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i+1, wrapping
// modulo N_SRC. idx_o is meaningful only when valid_o is high.
module msi_rr_pick
  import msi_arb_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]     req_i,
  input  logic [MSI_VEC_W-1:0] ptr_i,
  output logic [MSI_VEC_W-1:0] idx_o,
  output logic                 valid_o
);

  localparam int SUM_W = MSI_VEC_W + 1;

  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  logic [SUM_W-1:0]   base;
  logic [SUM_W-1:0]   off;
  logic [SUM_W-1:0]   sum;

  // Doubling the vector turns the wrap-around search into a plain shift.
  assign dbl  = {req_i, req_i};
  assign base = {1'b0, ptr_i} + SUM_W'(1);
  assign rot  = N_SRC'(dbl >> base);

  always_comb begin
    valid_o = 1'b0;
    off     = '0;
    for (int r = N_SRC - 1; r >= 0; r--) begin
      if (rot[r]) begin
        valid_o = 1'b1;
        off     = SUM_W'(r);
      end
    end
  end

  // base + off < 2*N_SRC, so a single conditional subtract is a full modulo.
  assign sum   = base + off;
  assign idx_o = (sum >= SUM_W'(N_SRC)) ? MSI_VEC_W'(sum - SUM_W'(N_SRC))
                                        : MSI_VEC_W'(sum);

endmodule

// File: rtl/msi_irq_arbiter.sv
// Edge-latching MSI arbiter: level IRQ lines become pending events serviced round-robin.
// Optional post-grant holdoff gap is built only when MSI_HOLDOFF_EN is defined.
module msi_irq_arbiter
  import msi_arb_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic                 axi_clk_pcie,
  input  logic                 sys_resetn,
  input  logic [N_SRC-1:0]     irq_i,
  input  logic                 msi_enabled,
  output logic                 msi_request,
  input  logic                 msi_grant,
  output logic [MSI_VEC_W-1:0] msi_vector,
  output logic [N_SRC-1:0]     pending_o
);

  if (N_SRC < 1 || N_SRC > MAX_SRC) begin : g_bad_n_src
    $error("msi_irq_arbiter: N_SRC must be in 1..32");
  end
  if (HOLDOFF_CYCLES < 0) begin : g_bad_holdoff
    $error("msi_irq_arbiter: HOLDOFF_CYCLES must be non-negative");
  end

  arb_state_e           state_q, state_d;
  logic [N_SRC-1:0]     irq_q;
  logic [N_SRC-1:0]     pending_q, pending_d;
  logic                 req_q, req_d;
  logic [MSI_VEC_W-1:0] vec_q, vec_d;
  logic [MSI_VEC_W-1:0] ptr_q, ptr_d;

  logic [N_SRC-1:0]     rise;
  logic [N_SRC-1:0]     vec_mask;
  logic [MSI_VEC_W-1:0] pick_idx;
  logic                 pick_valid;

  assign rise = irq_i & ~irq_q;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_vec_mask
    assign vec_mask[gi] = (vec_q == MSI_VEC_W'(gi));
  end

  msi_rr_pick #(
    .N_SRC (N_SRC)
  ) u_pick (
    .req_i   (pending_q),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef MSI_HOLDOFF_EN
  localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_done;

  // HOLDOFF_CYCLES of 0 or 1 both leave HOLD after a single clock.
  assign hold_done = (HOLDOFF_CYCLES <= 1) || (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1));

  always_ff @(posedge axi_clk_pcie or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    vec_d     = vec_q;
    ptr_d     = ptr_q;
    pending_d = pending_q | rise;
`ifdef MSI_HOLDOFF_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (msi_enabled && pick_valid) begin
          vec_d   = pick_idx;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // A grant already issued by the core is honoured even if enable drops with it.
        if (msi_grant) begin
          pending_d = (pending_q & ~vec_mask) | rise;
          ptr_d     = vec_q;
          req_d     = 1'b0;
`ifdef MSI_HOLDOFF_EN
          cnt_d     = '0;
          state_d   = ST_HOLD;
`else
          state_d   = ST_IDLE;
`endif
        end else if (!msi_enabled) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

`ifdef MSI_HOLDOFF_EN
      ST_HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (hold_done) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk_pcie or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q   <= ST_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      req_q     <= 1'b0;
      vec_q     <= '0;
      ptr_q     <= MSI_VEC_W'(N_SRC - 1);
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_i;
      pending_q <= pending_d;
      req_q     <= req_d;
      vec_q     <= vec_d;
      ptr_q     <= ptr_d;
    end
  end

  assign msi_request = req_q;
  assign msi_vector  = vec_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Directed scoreboard bench for msi_irq_arbiter (N_SRC=4, HOLDOFF_CYCLES=8).
// Expected vectors are queued when events are driven and popped when a request appears.
module tb_msi_irq_arbiter;

  localparam int N_SRC   = 4;
  localparam int HOLDOFF = 8;
`ifdef MSI_HOLDOFF_EN
  localparam int EXP_GAP = HOLDOFF + 1;
`else
  localparam int EXP_GAP = 1;
`endif

  logic             clk = 1'b0;
  logic             sys_resetn;
  logic [N_SRC-1:0] irq_i;
  logic             msi_enabled;
  logic             msi_request;
  logic             msi_grant;
  logic [4:0]       msi_vector;
  logic [N_SRC-1:0] pending_o;

  int         checks   = 0;
  int         failures = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  msi_irq_arbiter #(
    .N_SRC          (N_SRC),
    .HOLDOFF_CYCLES (HOLDOFF)
  ) dut (
    .axi_clk_pcie (clk),
    .sys_resetn   (sys_resetn),
    .irq_i        (irq_i),
    .msi_enabled  (msi_enabled),
    .msi_request  (msi_request),
    .msi_grant    (msi_grant),
    .msi_vector   (msi_vector),
    .pending_o    (pending_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, output int waited);
    waited = 0;
    while (msi_request !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    check({tag, "_req"}, 32'(msi_request), 32'd1);
  endtask

  task automatic check_vec(input string tag);
    logic [4:0] e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_vec"}, 32'(msi_vector), 32'(e));
      $display("txn %s: vector=%0d expected=%0d t=%0t", tag, msi_vector, e, $time);
    end
  endtask

  task automatic grant_after(input string tag, input int d);
    logic [4:0] v;
    v = msi_vector;
    for (int i = 0; i < d; i++) begin
      step();
      check({tag, "_hold_req"}, 32'(msi_request), 32'd1);
      check({tag, "_hold_vec"}, 32'(msi_vector), 32'(v));
    end
    msi_grant = 1'b1;
    step();
    msi_grant = 1'b0;
    check({tag, "_req_drop"}, 32'(msi_request), 32'd0);
  endtask

  task automatic serve(input string tag, input int d);
    int w;
    wait_req(tag, w);
    if (msi_request === 1'b1) begin
      check_vec(tag);
      grant_after(tag, d);
    end
  endtask

  initial begin
    int w;
    sys_resetn  = 1'b0;
    irq_i       = '0;
    msi_enabled = 1'b1;
    msi_grant   = 1'b0;
    step();
    step();
    check("rst_req", 32'(msi_request), 32'd0);
    check("rst_vec", 32'(msi_vector), 32'd0);
    check("rst_pend", 32'(pending_o), 32'd0);
    sys_resetn = 1'b1;
    step();
    step();

    // All four rise together: fresh pointer gives 0,1,2,3 then again 0,1,2,3.
    for (int round = 0; round < 2; round++) begin
      irq_i = 4'hF;
      step();
      irq_i = 4'h0;
      for (int s = 0; s < N_SRC; s++) exp_q.push_back(5'(s));
      for (int s = 0; s < N_SRC; s++) serve("t032", 1);
      check("t032_pend_clr", 32'(pending_o), 32'd0);
    end

    // Single-source pulse and latency.
    settle();
    irq_i = 4'b0100;
    step();
    check("t031_pend", 32'(pending_o), 32'h4);
    check("t031_req_early", 32'(msi_request), 32'd0);
    irq_i = 4'b0000;
    exp_q.push_back(5'd2);
    step();
    check("t031_req_lat", 32'(msi_request), 32'd1);
    check_vec("t031");
    grant_after("t031", 3);
    check("t031_pend_clr", 32'(pending_o), 32'd0);

    // New rise on the grant edge keeps the pending bit.
    irq_i = 4'b0010;
    step();
    irq_i = 4'b0000;
    exp_q.push_back(5'd1);
    wait_req("t033", w);
    check_vec("t033");
    irq_i     = 4'b0010;
    msi_grant = 1'b1;
    step();
    msi_grant = 1'b0;
    irq_i     = 4'b0000;
    check("t033_pend_kept", 32'(pending_o), 32'h2);
    check("t033_req_drop", 32'(msi_request), 32'd0);
    exp_q.push_back(5'd1);
    serve("t033b", 0);
    check("t033_pend_clr", 32'(pending_o), 32'd0);

    // Disabled MSI latches but does not request; stray grant is ignored.
    settle();
    msi_enabled = 1'b0;
    irq_i       = 4'b1000;
    step();
    irq_i = 4'b0000;
    step();
    step();
    check("t034_noreq", 32'(msi_request), 32'd0);
    check("t034_pend", 32'(pending_o), 32'h8);
    msi_grant = 1'b1;
    step();
    msi_grant = 1'b0;
    check("t020_grant_ignored", 32'(pending_o), 32'h8);
    exp_q.push_back(5'd3);
    msi_enabled = 1'b1;
    wait_req("t034", w);
    check("t034_lat_le2", 32'(w <= 2), 32'd1);
    check_vec("t034");
    grant_after("t034", 0);

    // Enable drops while requesting: request withdrawn, pending kept.
    irq_i = 4'b0001;
    step();
    irq_i = 4'b0000;
    wait_req("t019", w);
    msi_enabled = 1'b0;
    step();
    check("t019_req_drop", 32'(msi_request), 32'd0);
    check("t019_pend_kept", 32'(pending_o), 32'h1);
    msi_enabled = 1'b1;
    exp_q.push_back(5'd0);
    serve("t019", 0);

    // Repeated rises while pending coalesce into one MSI.
    msi_enabled = 1'b0;
    irq_i = 4'b0010; step();
    irq_i = 4'b0000; step();
    irq_i = 4'b0010; step();
    irq_i = 4'b0000; step();
    check("t022_pend", 32'(pending_o), 32'h2);
    exp_q.push_back(5'd1);
    msi_enabled = 1'b1;
    serve("t022", 0);
    step();
    step();
    step();
    check("t022_no_second", 32'(msi_request), 32'd0);
    check("t022_pend_clr", 32'(pending_o), 32'd0);

    // Two pending sources: gap from first grant to second request.
    irq_i = 4'b0101;
    step();
    irq_i = 4'b0000;
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd0);
    serve("t035a", 0);
    wait_req("t035b", w);
    check("t035_gap", 32'(w), 32'(EXP_GAP));
    check_vec("t035b");
    grant_after("t035b", 0);
    check("t035_pend_clr", 32'(pending_o), 32'd0);

    // Reset mid-request; lines held high through reset register as rises afterwards.
    settle();
    irq_i = 4'b0011;
    step();
    wait_req("t036_pre", w);
    check("t036_pre_vec", 32'(msi_vector), 32'd1);
    #2;
    sys_resetn = 1'b0;
    #1;
    check("t036_req_async", 32'(msi_request), 32'd0);
    check("t036_pend_async", 32'(pending_o), 32'd0);
    check("t036_vec_async", 32'(msi_vector), 32'd0);
    step();
    step();
    sys_resetn = 1'b1;
    step();
    check("t026_pend_after_rst", 32'(pending_o), 32'h3);
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd1);
    serve("t036a", 0);
    serve("t036b", 0);
    irq_i = 4'b0000;
    step();
    check("t036_pend_clr", 32'(pending_o), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
